// File: rtl/sync_down_counter.sv
// -----------------------------------------------------------------------------
// sync_down_counter
//
// Loadable synchronous down counter with one-shot and periodic auto-reload
// modes. A reload register (rl) remembers the last loaded value. In auto-reload
// mode the count runs rl, rl-1, ..., 1, 0 and then reloads, so one period is
// rl+1 enabled cycles. Each period produces exactly one terminal-count pulse,
// in the cycle in which Q becomes 0.
//
// Parameters
//   WIDTH        counter width in bits (2 or more)
//
// Ports
//   clk          single clock, rising-edge active
//   reset        asynchronous, active-high reset (Q=0, rl=0, IDLE, tc=0)
//   clr          synchronous clear to IDLE (Q=0, rl kept); highest priority
//   load         synchronous load of load_val (beats en)
//   load_val     start / reload value
//   en           count enable, one decrement per enabled edge while RUN
//   auto_reload  1 = periodic reload, 0 = one-shot
//   Q            current count (registered)
//   tc           terminal-count pulse, one cycle wide (registered)
//   busy         high while the state is RUN (registered)
//   zero         high when Q == 0 (combinational from Q)
// -----------------------------------------------------------------------------
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] rl_r;
  logic [WIDTH-1:0] rl_nxt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             busy_r;

  // Next-state / next-count decision with priority clr > load > en.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    rl_nxt_s    = rl_r;
    tc_nxt_s    = 1'b0;   // tc is a pulse: low unless this edge hits terminal count

    if (clr) begin
      q_nxt_s     = CNT_ZERO;
      state_nxt_s = ST_IDLE;
    end else if (load) begin
      q_nxt_s  = load_val;
      rl_nxt_s = load_val;
      // A zero load has nothing to count, so it finishes silently (no tc).
      if (load_val != CNT_ZERO) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = ST_DONE;
      end
    end else if (en) begin
      case (state_r)
        ST_RUN: begin
          if (q_r > CNT_ONE) begin
            q_nxt_s = q_r - CNT_ONE;
          end else if (q_r == CNT_ONE) begin
            // Reaching zero is the terminal count; mode decides whether we keep running.
            q_nxt_s = CNT_ZERO;
            tc_nxt_s = 1'b1;
            if (auto_reload) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            // Sitting at zero in RUN: reload, or stop if the mode was switched
            // to one-shot after the terminal count. Never wraps to all-ones.
            if (auto_reload) begin
              q_nxt_s = rl_r;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end
        end
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          // Unreachable encoding: fall back to a safe, stopped state.
          state_nxt_s = ST_IDLE;
          q_nxt_s     = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      q_nxt_s     = q_r;
    end
  end

  // State, count, reload and pulse registers; reset forces the idle condition at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      q_r     <= CNT_ZERO;
      rl_r    <= CNT_ZERO;
      tc_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      q_r     <= q_nxt_s;
      rl_r    <= rl_nxt_s;
      tc_r    <= tc_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
    end
  end

  assign Q    = q_r;
  assign tc   = tc_r;
  assign busy = busy_r;
  assign zero = (q_r == CNT_ZERO);

endmodule
